a2d_scan_ctrl: RTL and testbench

Channel scheduler and sequencer for the ADC128S 12-bit, 8-channel A2D converter. It sits between the existing 16-bit SPI master and the rest of the design. It scans a programmable set of channels on a fixed period, stores the latest result per channel, and arbitrates one-shot host conversion requests into the gaps between scans. It handles the converter's pipelined protocol: each transaction returns the result for the channel addressed in the *previous* transaction.

---
 rtl/a2d_scan_ctrl.sv | 166 ++++++++++++++++
 tb/tb_a2d_scan_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/a2d_scan_ctrl.sv
// Channel scheduler and sequencer for the ADC128S 8-channel A2D behind a 16-bit SPI master.
// The converter is pipelined: each transaction returns the channel addressed by the previous one.
module a2d_scan_ctrl #(
  parameter logic [15:0] PERIOD = 16'd4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scan_en,
  input  logic [7:0]  ch_en,
  input  logic        req,
  input  logic [2:0]  req_chnl,
  output logic        ack,
  output logic [11:0] res,
  input  logic [2:0]  rd_chnl,
  output logic [11:0] rd_data,
  output logic [7:0]  vld,
  output logic        busy,
  output logic        scan_done,
  output logic        spi_wrt,
  output logic [15:0] spi_cmd,
  input  logic        spi_done,
  input  logic [15:0] spi_rd
);

  typedef enum logic [2:0] {IDLE, S_TX, S_WT, H_TX, H_WT} state_t;

  localparam logic [15:0] TMAX = 16'(PERIOD - 16'd1);

  state_t      state, state_nxt;
  logic [15:0] timer;
  logic [7:0]  en_q;
  logic [2:0]  cur, prev;
  logic        first, flush, phase;
  logic [11:0] result [8];

  logic        expired;
  logic        scan_start, scan_adv, scan_fin, wr_res;
  logic        host_start, host_adv, host_fin;
  logic [3:0]  lowest, higher;
  logic        spi_rd_unused;

  // Returns {found, index} of the lowest set bit of m at or above position from.
  function automatic logic [3:0] next_set(input logic [7:0] m, input logic [3:0] from);
    logic [3:0] r;
    r = 4'b0000;
    for (int i = 7; i >= 0; i--) begin
      if (m[i] && (4'(i) >= from)) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  assign expired       = (timer == TMAX);
  assign lowest        = next_set(ch_en, 4'd0);
  assign higher        = next_set(en_q, {1'b0, cur} + 4'd1);
  assign spi_rd_unused = ^spi_rd[15:12];

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    scan_start = 1'b0;
    scan_adv   = 1'b0;
    scan_fin   = 1'b0;
    wr_res     = 1'b0;
    host_start = 1'b0;
    host_adv   = 1'b0;
    host_fin   = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          host_start = 1'b1;
          state_nxt  = H_TX;
        end else if (scan_en && expired && (ch_en != 8'h00)) begin
          scan_start = 1'b1;
          state_nxt  = S_TX;
        end
      end
      S_TX: state_nxt = S_WT;
      S_WT: begin
        if (spi_done) begin
          wr_res = !first;
          if (flush) begin
            scan_fin  = 1'b1;
            state_nxt = IDLE;
          end else begin
            scan_adv  = 1'b1;
            state_nxt = S_TX;
          end
        end
      end
      H_TX: state_nxt = H_WT;
      H_WT: begin
        if (spi_done) begin
          if (phase) begin
            host_fin  = 1'b1;
            state_nxt = IDLE;
          end else begin
            host_adv  = 1'b1;
            state_nxt = H_TX;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timer     <= 16'h0000;
      en_q      <= 8'h00;
      cur       <= 3'd0;
      prev      <= 3'd0;
      first     <= 1'b0;
      flush     <= 1'b0;
      phase     <= 1'b0;
      res       <= 12'h000;
      ack       <= 1'b0;
      scan_done <= 1'b0;
      vld       <= 8'h00;
      for (int i = 0; i < 8; i++) result[i] <= 12'h000;
    end else begin
      ack       <= 1'b0;
      scan_done <= 1'b0;
      if (scan_start)        timer <= 16'h0000;
      else if (!expired)     timer <= timer + 16'd1;

      if (host_start) begin
        cur   <= req_chnl;
        phase <= 1'b0;
      end
      if (host_adv) phase <= 1'b1;
      if (host_fin) begin
        res <= spi_rd[11:0];
        ack <= 1'b1;
      end

      if (scan_start) begin
        en_q  <= ch_en;
        cur   <= lowest[2:0];
        first <= 1'b1;
        flush <= 1'b0;
      end
      if (wr_res) begin
        result[prev] <= spi_rd[11:0];
        vld[prev]    <= 1'b1;
      end
      if (scan_fin) scan_done <= 1'b1;
      // With no higher channel left, one more transaction re-addresses cur to flush its result.
      if (scan_adv) begin
        prev  <= cur;
        first <= 1'b0;
        if (higher[3]) cur   <= higher[2:0];
        else           flush <= 1'b1;
      end
    end
  end

  assign busy    = (state != IDLE);
  assign spi_wrt = (state == S_TX) || (state == H_TX);
  assign spi_cmd = {2'b00, cur, 11'h000};
  assign rd_data = result[rd_chnl];

endmodule

// File: tb/tb_a2d_scan_ctrl.sv
// Bench for a2d_scan_ctrl: an SPI responder with random latency/data and a reference model
// built from the channel list of each scan (N+1 transactions, result[k] = response k+1).
module tb_a2d_scan_ctrl;
  localparam logic [15:0] PERIOD = 16'd64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scan_en = 1'b0;
  logic [7:0]  ch_en = 8'h00;
  logic        req = 1'b0;
  logic [2:0]  req_chnl = 3'd0;
  logic        ack;
  logic [11:0] res;
  logic [2:0]  rd_chnl = 3'd0;
  logic [11:0] rd_data;
  logic [7:0]  vld;
  logic        busy;
  logic        scan_done;
  logic        spi_wrt;
  logic [15:0] spi_cmd;
  logic        spi_done = 1'b0;
  logic [15:0] spi_rd = 16'h0000;

  a2d_scan_ctrl #(.PERIOD(PERIOD)) dut (
    .clk(clk), .rst_n(rst_n), .scan_en(scan_en), .ch_en(ch_en),
    .req(req), .req_chnl(req_chnl), .ack(ack), .res(res),
    .rd_chnl(rd_chnl), .rd_data(rd_data), .vld(vld), .busy(busy),
    .scan_done(scan_done), .spi_wrt(spi_wrt), .spi_cmd(spi_cmd),
    .spi_done(spi_done), .spi_rd(spi_rd)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] exp_q[$];
  logic [11:0] exp_res [8];
  logic [7:0]  exp_vld = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Waits for spi_wrt, checks the command against the queue, answers after a random delay.
  task automatic serve_txn(output logic [11:0] data, output int wrt_cyc);
    int waited = 0;
    int dly;
    logic [15:0] exp_cmd;
    while (spi_wrt !== 1'b1 && waited < 4 * PERIOD) begin
      @(negedge clk);
      waited++;
    end
    data = 12'h000;
    wrt_cyc = cyc;
    if (spi_wrt !== 1'b1) begin
      check("wrt_timeout", 0, 1);
      return;
    end
    if (exp_q.size() == 0) begin
      check("txn_unexpected", 1, 0);
      exp_cmd = 16'hFFFF;
    end else begin
      exp_cmd = exp_q.pop_front();
    end
    check("spi_cmd", spi_cmd, exp_cmd);
    check("busy", busy, 1);
    dly = $urandom_range(1, 5);
    repeat (dly) begin
      @(negedge clk);
      check("wrt_pulse", spi_wrt, 0);
      check("cmd_hold", spi_cmd, exp_cmd);
    end
    data = 12'($urandom_range(0, 4095));
    spi_rd = {4'($urandom_range(0, 15)), data};
    spi_done = 1'b1;
    @(negedge clk);
    spi_done = 1'b0;
    spi_rd = 16'($urandom);
  endtask

  task automatic check_results();
    for (int i = 0; i < 8; i++) begin
      rd_chnl = 3'(i);
      #1;
      check($sformatf("rd_data%0d", i), rd_data, exp_res[i]);
    end
    check("vld", vld, exp_vld);
    @(negedge clk);
  endtask

  task automatic run_scan(input logic [7:0] mask, input logic [7:0] new_en, input int chg_at,
                          input int req_at, input logic [2:0] rch, output int start_cyc);
    logic [2:0] chs[$];
    logic [11:0] d;
    int n;
    int wc;
    for (int i = 0; i < 8; i++) if (mask[i]) chs.push_back(3'(i));
    n = chs.size();
    for (int k = 0; k <= n; k++) exp_q.push_back({2'b00, chs[(k < n) ? k : n - 1], 11'h000});
    start_cyc = 0;
    for (int k = 0; k <= n; k++) begin
      serve_txn(d, wc);
      if (k == 0) start_cyc = wc;
      if (k > 0) begin
        exp_res[chs[k-1]] = d;
        exp_vld[chs[k-1]] = 1'b1;
      end
      check("scan_done", scan_done, (k == n) ? 1 : 0);
      if (k == chg_at) ch_en = new_en;
      if (k == req_at) begin
        req = 1'b1;
        req_chnl = rch;
      end
    end
    @(negedge clk);
    check("scan_done_pulse", scan_done, 0);
  endtask

  task automatic do_host(input logic [2:0] ch, output int ack_cyc);
    logic [11:0] d;
    int wc;
    req = 1'b1;
    req_chnl = ch;
    exp_q.push_back({2'b00, ch, 11'h000});
    exp_q.push_back({2'b00, ch, 11'h000});
    serve_txn(d, wc);
    check("ack_early", ack, 0);
    serve_txn(d, wc);
    check("ack", ack, 1);
    check("res", res, d);
    ack_cyc = cyc;
    req = 1'b0;
    @(negedge clk);
    check("ack_pulse", ack, 0);
  endtask

  initial begin
    int c0, s1, s2, a;
    int waited;
    for (int i = 0; i < 8; i++) exp_res[i] = 12'h000;

    // Reset state
    ch_en = 8'h05;
    scan_en = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_wrt", spi_wrt, 0);
    check("rst_cmd", spi_cmd, 16'h0000);
    check("rst_ack", ack, 0);
    check("rst_res", res, 0);
    check("rst_done", scan_done, 0);
    check("rst_vld", vld, 0);
    rst_n = 1'b1;
    c0 = cyc;

    // Scan of 8'h05 twice: start timing and period spacing
    run_scan(8'h05, 8'h05, -1, -1, 3'd0, s1);
    check("first_start", 32'(s1 - c0), 32'(PERIOD));
    run_scan(8'h05, 8'h05, -1, -1, 3'd0, s2);
    check("period", 32'(s2 - s1), 32'(PERIOD));
    scan_en = 1'b0;
    check_results();

    // Single channel 7
    ch_en = 8'h80;
    scan_en = 1'b1;
    run_scan(8'h80, 8'h80, -1, -1, 3'd0, s1);
    scan_en = 1'b0;
    check_results();

    // Host request, no scan
    do_host(3'd3, a);
    check_results();

    // Host request coinciding with timer expiry, then req raised mid-scan
    ch_en = 8'h05;
    scan_en = 1'b1;
    run_scan(8'h05, 8'h05, -1, -1, 3'd0, s1);
    while (cyc < s1 + int'(PERIOD) - 1) @(negedge clk);
    do_host(3'd6, a);
    run_scan(8'h05, 8'h05, -1, 1, 3'd2, s2);
    check("scan_after_ack", 32'(s2 - a), 1);
    do_host(3'd2, a);
    scan_en = 1'b0;
    check_results();

    // ch_en change mid-scan takes effect only on the next scan
    ch_en = 8'h03;
    scan_en = 1'b1;
    run_scan(8'h03, 8'hFF, 1, -1, 3'd0, s1);
    run_scan(8'hFF, 8'hFF, -1, -1, 3'd0, s2);
    scan_en = 1'b0;
    check_results();

    // Randomized scans and host requests
    for (int it = 0; it < 6; it++) begin
      logic [7:0] m;
      if ($urandom_range(0, 1) == 1) do_host(3'($urandom_range(0, 7)), a);
      m = 8'($urandom_range(1, 255));
      ch_en = m;
      scan_en = 1'b1;
      run_scan(m, m, -1, -1, 3'd0, s1);
      scan_en = 1'b0;
      check_results();
    end

    // Reset while waiting for spi_done, then a stray spi_done
    ch_en = 8'h0F;
    scan_en = 1'b1;
    waited = 0;
    while (spi_wrt !== 1'b1 && waited < 4 * PERIOD) begin
      @(negedge clk);
      waited++;
    end
    check("rst_test_start", spi_wrt, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    scan_en = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_res[i] = 12'h000;
    exp_vld = 8'h00;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_wrt", spi_wrt, 0);
    check("mid_rst_cmd", spi_cmd, 16'h0000);
    check("mid_rst_ack", ack, 0);
    check("mid_rst_res", res, 0);
    check("mid_rst_done", scan_done, 0);
    check("mid_rst_vld", vld, 0);
    spi_rd = 16'h0ABC;
    spi_done = 1'b1;
    @(negedge clk);
    spi_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("stray_ack", ack, 0);
      check("stray_busy", busy, 0);
    end
    check_results();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
